lint_2_apb: RTL and testbench

Single-outstanding bridge from the core-side request/grant (lint) bus to the APB slave port of the peripheral address decoder. It converts each accepted lint request into one APB SETUP/ACCESS transfer and waits for `pready`. It bounds the wait with a programmable timeout, then returns a registered one-cycle response carrying read data, error flag and transaction ID. It sits directly upstream of the APB decoder node; its APB outputs drive that node's slave port.

---
 rtl/lint_2_apb_if.sv | 48 ++++
 rtl/lint_2_apb.sv | 129 ++++++++++++
 tb/tb_lint_2_apb.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/lint_2_apb_if.sv
`default_nettype none
// ============================================================================
// Module   : lint_2_apb_if
// Brief    : Lint request/response and APB3 master signal bundle for the
//            lint-to-APB bridge.
// Revision : 1.0 - initial release
// ============================================================================
interface lint_2_apb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic                    data_req_i;
    logic [ADDR_WIDTH-1:0]   data_add_i;
    logic                    data_wen_i;
    logic [DATA_WIDTH-1:0]   data_wdata_i;
    logic [DATA_WIDTH/8-1:0] data_be_i;
    logic [ID_WIDTH-1:0]     data_ID_i;
    logic                    data_gnt_o;
    logic                    data_r_valid_o;
    logic [DATA_WIDTH-1:0]   data_r_rdata_o;
    logic                    data_r_opc_o;
    logic [ID_WIDTH-1:0]     data_r_ID_o;
    logic                    psel_o;
    logic                    penable_o;
    logic                    pwrite_o;
    logic [ADDR_WIDTH-1:0]   paddr_o;
    logic [DATA_WIDTH-1:0]   pwdata_o;
    logic [DATA_WIDTH-1:0]   prdata_i;
    logic                    pready_i;
    logic                    pslverr_i;

    // The bridge itself sits on the slave side of the lint bus.
    modport slave (
        input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i,
               data_ID_i, prdata_i, pready_i, pslverr_i,
        output data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o,
               data_r_ID_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );

    modport master (
        output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i,
               data_ID_i, prdata_i, pready_i, pslverr_i,
        input  data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o,
               data_r_ID_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );
endinterface
`default_nettype wire

// File: rtl/lint_2_apb.sv
`default_nettype none
// ============================================================================
// Module   : lint_2_apb
// Brief    : Single-outstanding lint-to-APB3 bridge with access timeout and
//            registered one-cycle response.
// Revision : 1.0 - initial release
// ============================================================================
module lint_2_apb #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire logic   clk_i,
    input  wire logic   rst_i,
    lint_2_apb_if.slave bus
);
    localparam int              CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [ID_WIDTH-1:0]   r_id;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_opc;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_accept;
    logic                  w_timeout;
    logic                  unused_be;

    // APB3 has no write strobes, so byte enables are intentionally dropped.
    assign unused_be = ^bus.data_be_i;

    assign w_accept  = (r_state == S_IDLE) && bus.data_req_i;
    assign w_timeout = TIMEOUT_EN && (r_cnt == CNT_LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.data_req_i) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (bus.pready_i || w_timeout) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Bus controls are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_valid   <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_id      <= '0;
            r_rdata   <= '0;
            r_opc     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_psel    <= (w_next == S_SETUP) || (w_next == S_ACCESS);
            r_penable <= (w_next == S_ACCESS);
            r_valid   <= (w_next == S_RESP);

            if (w_accept) begin
                r_paddr  <= bus.data_add_i;
                r_pwdata <= bus.data_wdata_i;
                r_pwrite <= !bus.data_wen_i;
                r_id     <= bus.data_ID_i;
            end

            // Saturating wait counter; only compared when the timeout is enabled.
            if (r_state == S_SETUP) begin
                r_cnt <= '0;
            end else if ((r_state == S_ACCESS) && !bus.pready_i && !w_timeout
                         && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // A completing slave takes priority over an expiring timeout.
            if (r_state == S_ACCESS) begin
                if (bus.pready_i) begin
                    r_rdata <= (r_pwrite || bus.pslverr_i) ? '0 : bus.prdata_i;
                    r_opc   <= bus.pslverr_i;
                end else if (w_timeout) begin
                    r_rdata <= '0;
                    r_opc   <= 1'b1;
                end
            end
        end
    end

    assign bus.data_gnt_o     = w_accept;
    assign bus.data_r_valid_o = r_valid;
    assign bus.data_r_rdata_o = r_rdata;
    assign bus.data_r_opc_o   = r_opc;
    assign bus.data_r_ID_o    = r_id;
    assign bus.psel_o         = r_psel;
    assign bus.penable_o      = r_penable;
    assign bus.pwrite_o       = r_pwrite;
    assign bus.paddr_o        = r_paddr;
    assign bus.pwdata_o       = r_pwdata;
endmodule
`default_nettype wire

// File: tb/tb_lint_2_apb.sv
`default_nettype none
// ============================================================================
// Module   : tb_lint_2_apb
// Brief    : Self-checking bench for lint_2_apb: directed cases plus random
//            transactions against a transaction-level response model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lint_2_apb;
    localparam int T = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   cyc;
    int   last_gnt_cyc;
    int   exp_gap;

    lint_2_apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

    lint_2_apb #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle; finishes at the negedge of the
    // first idle cycle after the response (or after a mid-access reset).
    task automatic run_txn(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                           input logic [3:0] id, input int w, input logic err,
                           input logic [31:0] prd, input bit hold, input bit rst_mid);
        int         last;
        logic [31:0] exp_rd;
        logic       exp_opc;
        bus.data_req_i   = 1'b1;
        bus.data_add_i   = addr;
        bus.data_wen_i   = wen;
        bus.data_wdata_i = wdata;
        bus.data_be_i    = 4'($urandom);
        bus.data_ID_i    = id;
        #1;
        chk("gnt_idle", bus.data_gnt_o, 1'b1);
        chk("valid_idle", bus.data_r_valid_o, 1'b0);
        if (exp_gap >= 0) chk("gnt_gap", cyc - last_gnt_cyc, exp_gap);
        last_gnt_cyc = cyc;

        next_cycle();
        bus.data_req_i = hold;
        bus.data_add_i = $urandom;
        bus.data_ID_i  = 4'($urandom);
        #1;
        chk("setup_psel", bus.psel_o, 1'b1);
        chk("setup_penable", bus.penable_o, 1'b0);
        chk("setup_paddr", bus.paddr_o, addr);
        chk("setup_pwrite", bus.pwrite_o, !wen);
        chk("setup_pwdata", bus.pwdata_o, wdata);
        chk("setup_gnt", bus.data_gnt_o, 1'b0);
        chk("setup_valid", bus.data_r_valid_o, 1'b0);

        last = (w < T) ? w : T - 1;
        for (int j = 0; j <= last; j++) begin
            next_cycle();
            #1;
            chk("acc_psel", bus.psel_o, 1'b1);
            chk("acc_penable", bus.penable_o, 1'b1);
            chk("acc_paddr", bus.paddr_o, addr);
            chk("acc_pwdata", bus.pwdata_o, wdata);
            chk("acc_gnt", bus.data_gnt_o, 1'b0);
            chk("acc_valid", bus.data_r_valid_o, 1'b0);
            if (rst_mid && j == 1) begin
                bus.data_req_i = 1'b0;
                bus.pready_i   = 1'b0;
                rst = 1'b1;
                next_cycle();
                rst = 1'b0;
                #1;
                chk("rst_psel", bus.psel_o, 1'b0);
                chk("rst_penable", bus.penable_o, 1'b0);
                chk("rst_valid", bus.data_r_valid_o, 1'b0);
                chk("rst_paddr", bus.paddr_o, 32'h0);
                chk("rst_pwdata", bus.pwdata_o, 32'h0);
                chk("rst_id", bus.data_r_ID_o, 4'h0);
                exp_gap = -1;
                return;
            end
            bus.pready_i  = (j == w);
            bus.pslverr_i = err;
            bus.prdata_i  = prd;
        end

        next_cycle();
        bus.pready_i  = 1'b0;
        bus.pslverr_i = 1'b0;
        bus.prdata_i  = $urandom;
        if (w >= T) begin
            exp_opc = 1'b1;
            exp_rd  = 32'h0;
        end else begin
            exp_opc = err;
            exp_rd  = (!wen || err) ? 32'h0 : prd;
        end
        #1;
        chk("resp_valid", bus.data_r_valid_o, 1'b1);
        chk("resp_rdata", bus.data_r_rdata_o, exp_rd);
        chk("resp_opc", bus.data_r_opc_o, exp_opc);
        chk("resp_id", bus.data_r_ID_o, id);
        chk("resp_psel", bus.psel_o, 1'b0);
        chk("resp_penable", bus.penable_o, 1'b0);
        chk("resp_paddr", bus.paddr_o, addr);
        chk("resp_gnt", bus.data_gnt_o, 1'b0);

        next_cycle();
        exp_gap = 4 + last;
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        cyc            = 0;
        last_gnt_cyc   = 0;
        exp_gap        = -1;
        rst            = 1'b1;
        bus.data_req_i = 1'b0;
        bus.data_add_i = '0;
        bus.data_wen_i = 1'b0;
        bus.data_wdata_i = '0;
        bus.data_be_i  = '0;
        bus.data_ID_i  = '0;
        bus.prdata_i   = '0;
        bus.pready_i   = 1'b0;
        bus.pslverr_i  = 1'b0;
        repeat (3) next_cycle();
        #1;
        chk("reset_psel", bus.psel_o, 1'b0);
        chk("reset_penable", bus.penable_o, 1'b0);
        chk("reset_pwrite", bus.pwrite_o, 1'b0);
        chk("reset_paddr", bus.paddr_o, 32'h0);
        chk("reset_pwdata", bus.pwdata_o, 32'h0);
        chk("reset_valid", bus.data_r_valid_o, 1'b0);
        chk("reset_rdata", bus.data_r_rdata_o, 32'h0);
        chk("reset_opc", bus.data_r_opc_o, 1'b0);
        chk("reset_id", bus.data_r_ID_o, 4'h0);
        chk("reset_gnt", bus.data_gnt_o, 1'b0);
        rst = 1'b0;
        next_cycle();

        run_txn(32'h1A10_0004, 1'b1, 32'h0,         4'd3, 0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0);
        run_txn(32'h1A10_0008, 1'b0, 32'h1234_5678, 4'd5, 2, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        run_txn(32'h1A10_000C, 1'b1, 32'h0,         4'd6, 0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_txn(32'h1A10_0010, 1'b1, 32'h0,         4'd7, 9, 1'b0, 32'h5555_AAAA, 1'b0, 1'b0);
        run_txn(32'h1A10_0014, 1'b1, 32'h0,         4'd8, 3, 1'b0, 32'h0BAD_CAFE, 1'b0, 1'b0);
        run_txn(32'h1A10_0018, 1'b1, 32'h0,         4'd1, 0, 1'b0, 32'h1111_1111, 1'b1, 1'b0);
        run_txn(32'h1A10_001C, 1'b1, 32'h0,         4'd2, 0, 1'b0, 32'h2222_2222, 1'b0, 1'b0);
        run_txn(32'h1A10_0020, 1'b0, 32'h7777_0000, 4'd9, 5, 1'b0, 32'h0,         1'b0, 1'b1);
        run_txn(32'h1A10_0024, 1'b1, 32'h0,         4'd4, 1, 1'b0, 32'h3333_4444, 1'b0, 1'b0);

        for (int k = 0; k < 150; k++) begin
            bit hold_r;
            hold_r = ($urandom_range(0, 1) == 1);
            run_txn($urandom, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 5),
                    ($urandom_range(0, 3) == 0), $urandom, hold_r, 1'b0);
            if (!hold_r && $urandom_range(0, 2) == 0) begin
                bus.data_req_i = 1'b0;
                #1;
                chk("gap_gnt", bus.data_gnt_o, 1'b0);
                next_cycle();
                exp_gap = -1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
